data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
Parametrised, clocked word-organised data memory with a valid/ready request port and a buffered response port. Replaces the level-sensitive, single-width memory with byte-addressed, byte-strobed, fixed-latency access and protocol-level errors. It sits behind the core's load/store stage and serves one request per cycle when it is not backpressured.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8 and at least 8.
ADDR_W, 32, byte-address width.
DEPTH, 256, number of words; must be a power of two.
READ_LAT, 1, cycles from request acceptance to response FIFO entry; range 1..4.
RSP_DEPTH, READ_LAT+1, response FIFO entries; must be at least READ_LAT+1.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request can be accepted this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_wstrb  in  DATA_W/8  byte write enables; bit i gates bits [8i+7:8i].
rsp_valid  out  1  response available at FIFO head.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
rsp_err  out  1  request was misaligned or out of range.
rsp_write  out  1  echoes req_write of the responded request.

Behaviour:
- Definitions: OFF = log2(DATA_W/8); IDX = log2(DEPTH). Word index = req_addr[OFF+IDX-1:OFF].
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- Error condition: any req_addr[OFF-1:0] != 0, or any req_addr bit at or above OFF+IDX set. An errored request performs no memory access. It still produces exactly one response, with rsp_err=1 and rsp_rdata=0.
- Write: the strobed bytes are committed at the acceptance edge; unstrobed bytes are unchanged. If req_wstrb=0, no byte changes, but an ack is still produced (rsp_write=1, rsp_err=0, rsp_rdata=0).
- Read: the memory is sampled at the acceptance edge. A read accepted in the cycle after a write to the same word returns the new data. No same-cycle read/write conflict exists, because there is one request per cycle.
- Pipeline: each accepted request enters a READ_LAT-deep shift pipeline carrying {write, err, rdata}. At stage exit it is pushed into the response FIFO. Earliest rsp_valid is READ_LAT cycles after acceptance.
- FIFO: responses leave in acceptance order. Pop on rsp_valid && rsp_ready. rsp_* show the head entry and stay stable while rsp_valid && !rsp_ready.
- Flow control: outstanding counter, range 0..RSP_DEPTH.
  - +1 on accept, -1 on pop; simultaneous accept and pop leaves it unchanged.
  - req_ready = (outstanding < RSP_DEPTH) && !rst.
  - This guarantees the FIFO never overflows; no response is ever dropped.
- Full condition: with outstanding == RSP_DEPTH, req_ready=0 until a pop. In the pop cycle req_ready stays 0 (registered counter); it rises the next cycle.
- Pointer wrap: FIFO pointers wrap modulo RSP_DEPTH. Full/empty is decided from the count, not pointer equality.
- Reset: asynchronous, and may assert mid-operation. Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_write=0, outstanding=0, pipeline valids=0, FIFO pointers=0. req_ready=0 during reset and 1 in the first cycle after deassertion.
- Memory across reset: contents are not reset; writes committed before reset persist. In-flight responses are discarded.

Test Plan:
1. Reset, then write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then read 0x10 -> write ack (rsp_write=1, rdata=0), then read rsp_rdata=0xDEADBEEF at READ_LAT cycles after acceptance, rsp_err=0.
2. Write 0x11223344 to 0x20 with strobe 0xF, then 0xAABBCCDD with strobe 0x5, then read 0x20 -> 0x11BB33DD; a wstrb=0 write yields an ack and the data is unchanged.
3. Read 0x22 (misaligned) and read 0x400 (DEPTH=256, out of range) -> two responses, rsp_err=1, rdata=0; memory unchanged.
4. Hold rsp_ready=0 with req_valid=1 for 10 cycles -> exactly RSP_DEPTH accepts, then req_ready=0. Head response stays stable. After release, all responses drain in acceptance order with none lost.
5. Back-to-back reads of 0x0, 0x4, 0x8 with rsp_ready=1 -> one response per cycle, in order, throughput 1/cycle.
6. Assert rst while 2 responses are outstanding -> rsp_valid=0 immediately; after release a read of a previously written word returns the pre-reset data.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the data memory controller.
interface data_memory_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_write;

    // Requester side (load/store stage).
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write
    );

    // Memory side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte strobes, fixed read latency,
// address error reporting and a credit-limited response FIFO.
module data_memory_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned RSP_DEPTH = READ_LAT + 1
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_ctrl_if.slave   bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned IDX   = $clog2(DEPTH);
    localparam int unsigned IDX_W = (IDX == 0) ? 1 : IDX;
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF) - 64'd1);

    logic                w_accept;
    logic                w_pop;
    logic                w_misalign;
    logic                w_oor;
    logic                w_err;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_rsp_valid;

    logic                w_push;
    logic                w_push_write;
    logic                w_push_err;
    logic [DATA_W-1:0]   w_push_rdata;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_fifo_rdata [RSP_DEPTH];
    logic                r_fifo_err   [RSP_DEPTH];
    logic                r_fifo_write [RSP_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_fifo_cnt;
    logic [CNT_W-1:0]    r_outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Address decode, error detection and combinational memory read.
    assign w_misalign = (bus.req_addr & OFF_MASK) != '0;
    assign w_oor      = (bus.req_addr >> (OFF + IDX)) != '0;
    assign w_err      = w_misalign || w_oor;
    assign w_idx      = IDX_W'(bus.req_addr >> OFF);
    assign w_rdata    = (!bus.req_write && !w_err) ? r_mem[w_idx] : '0;

    // Handshakes; the credit counter alone guarantees FIFO space.
    assign bus.req_ready = (r_outstanding < CNT_W'(RSP_DEPTH)) && !rst;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_rsp_valid   = (r_fifo_cnt != '0);
    assign w_pop         = w_rsp_valid && bus.rsp_ready;

    // Response head; zeroed when the FIFO is empty.
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_rdata = w_rsp_valid ? r_fifo_rdata[r_rd_ptr] : '0;
    assign bus.rsp_err   = w_rsp_valid ? r_fifo_err[r_rd_ptr]   : 1'b0;
    assign bus.rsp_write = w_rsp_valid ? r_fifo_write[r_rd_ptr] : 1'b0;

    // Strobed byte writes at the acceptance edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_err) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.req_wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // The FIFO register is the final latency stage, so READ_LAT-1 extra
    // stages sit between acceptance and the FIFO write.
    if (READ_LAT == 1) begin : g_direct
        assign w_push       = w_accept;
        assign w_push_write = bus.req_write;
        assign w_push_err   = w_err;
        assign w_push_rdata = w_rdata;
    end else begin : g_pipe
        localparam int unsigned STG = READ_LAT - 1;
        logic              r_vld [STG];
        logic              r_wr  [STG];
        logic              r_er  [STG];
        logic [DATA_W-1:0] r_rd  [STG];

        // Shift pipeline carrying {write, err, rdata}; in-flight entries drop on reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < STG; i++) begin
                    r_vld[i] <= 1'b0;
                    r_wr[i]  <= 1'b0;
                    r_er[i]  <= 1'b0;
                    r_rd[i]  <= '0;
                end
            end else begin
                r_vld[0] <= w_accept;
                r_wr[0]  <= bus.req_write;
                r_er[0]  <= w_err;
                r_rd[0]  <= w_rdata;
                for (int i = 1; i < STG; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_wr[i]  <= r_wr[i-1];
                    r_er[i]  <= r_er[i-1];
                    r_rd[i]  <= r_rd[i-1];
                end
            end
        end

        assign w_push       = r_vld[STG-1];
        assign w_push_write = r_wr[STG-1];
        assign w_push_err   = r_er[STG-1];
        assign w_push_rdata = r_rd[STG-1];
    end

    // FIFO storage; entries are only visible through the counted head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rdata[r_wr_ptr] <= w_push_rdata;
            r_fifo_err[r_wr_ptr]   <= w_push_err;
            r_fifo_write[r_wr_ptr] <= w_push_write;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // Outstanding requests: accepted but not yet popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl with a reference-model scoreboard.
module tb_data_memory_ctrl;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned READ_LAT  = 1;
    localparam int unsigned RSP_DEPTH = READ_LAT + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    data_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc;
    int          total;
    int          bad;
    int          n_acc;
    int          n_pop;
    bit          lat_exact;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one accepted request.
    function automatic exp_t model_req(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb);
        exp_t        e;
        logic [7:0]  idx;
        logic [31:0] hi;
        idx = addr[9:2];
        hi  = addr >> 10;
        e.wr    = wr;
        e.err   = (addr[1:0] != 2'b00) || (hi != 32'd0);
        e.rdata = 32'd0;
        e.acc_cyc = 0;
        if (!e.err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end else begin
                e.rdata = model_mem[idx];
            end
        end
        return e;
    endfunction

    // One clock: score any pop, record any accept, advance to next falling edge.
    task automatic tick();
        exp_t e;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                chk("rsp_err",   64'(bus.rsp_err),   64'(e.err));
                chk("rsp_write", 64'(bus.rsp_write), 64'(e.wr));
                if (lat_exact) chk("latency", 64'(cyc - e.acc_cyc), 64'(READ_LAT));
                n_pop++;
            end
        end
        if (bus.req_valid && bus.req_ready) begin
            e = model_req(bus.req_write, bus.req_addr, bus.req_wdata, bus.req_wstrb);
            e.acc_cyc = cyc;
            sb.push_back(e);
            n_acc++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        int w;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!bus.req_ready) chk("send_timeout", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Read with an explicit expected constant, on top of the scoreboard check.
    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int n;
        drain();
        send(1'b0, addr, 32'd0, 4'd0);
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.rsp_rdata), 64'(exp));
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] head;
        bit          have_head;
        bit          was_ready;
        int          acc0;
        int          pop0;

        total = 0; bad = 0; cyc = 0; n_acc = 0; n_pop = 0; lat_exact = 1'b1;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0;   bus.rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst_rsp_write", 64'(bus.rsp_write), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(bus.req_ready), 64'd1);

        // 1: full write then read with exact latency
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        read_check("rd_0x10", 32'h10, 32'hDEADBEEF);

        // 2: partial strobes and empty strobe
        send(1'b1, 32'h20, 32'h11223344, 4'hF);
        send(1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
        read_check("rd_strb5", 32'h20, 32'h11BB33DD);
        send(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        read_check("rd_strb0", 32'h20, 32'h11BB33DD);

        // 3: misaligned and out-of-range requests
        send(1'b0, 32'h22, 32'd0, 4'd0);
        send(1'b0, 32'h400, 32'd0, 4'd0);
        send(1'b1, 32'h22, 32'h55555555, 4'hF);
        send(1'b1, 32'h420, 32'h66666666, 4'hF);
        read_check("rd_after_err", 32'h20, 32'h11BB33DD);

        // 4: backpressure fills credits, head holds, then drains in order
        for (int i = 0; i < 4; i++) send(1'b1, 32'h40 + 32'(4*i), 32'hA0A0_0000 + 32'(i), 4'hF);
        drain();
        lat_exact = 1'b0;
        acc0 = n_acc;
        pop0 = n_pop;
        bus.rsp_ready = 1'b0;
        addr = 32'h40;
        have_head = 1'b0;
        head = '0;
        bus.req_write = 1'b0; bus.req_addr = addr; bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            was_ready = bus.req_ready;
            tick();
            if (was_ready) begin
                addr = addr + 32'd4;
                bus.req_addr = addr;
            end
            if (!have_head && bus.rsp_valid) begin
                head = bus.rsp_rdata;
                have_head = 1'b1;
            end
        end
        bus.req_valid = 1'b0;
        chk("full_accepts", 64'(n_acc - acc0), 64'(RSP_DEPTH));
        chk("full_ready",   64'(bus.req_ready), 64'd0);
        chk("head_stable",  64'(bus.rsp_rdata), 64'(head));
        chk("head_value",   64'(bus.rsp_rdata), 64'hA0A0_0000);
        bus.rsp_ready = 1'b1;
        chk("pop_cycle_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("ready_after_pop", 64'(bus.req_ready), 64'd1);
        drain();
        chk("drained_all", 64'(n_pop - pop0), 64'(RSP_DEPTH));
        lat_exact = 1'b1;

        // 5: back-to-back reads at one per cycle
        send(1'b1, 32'h0, 32'h0000_1111, 4'hF);
        send(1'b1, 32'h4, 32'h0000_2222, 4'hF);
        send(1'b1, 32'h8, 32'h0000_3333, 4'hF);
        drain();
        acc0 = n_acc;
        acc0 = acc0 + 0;
        pop0 = cyc;
        send(1'b0, 32'h0, 32'd0, 4'd0);
        send(1'b0, 32'h4, 32'd0, 4'd0);
        send(1'b0, 32'h8, 32'd0, 4'd0);
        chk("b2b_cycles", 64'(cyc - pop0), 64'd3);
        chk("b2b_accepts", 64'(n_acc - acc0), 64'd3);
        drain();

        // 6: reset with responses outstanding; memory persists
        send(1'b1, 32'h80, 32'hCAFEF00D, 4'hF);
        drain();
        lat_exact = 1'b0;
        bus.rsp_ready = 1'b0;
        send(1'b0, 32'h0, 32'd0, 4'd0);
        send(1'b0, 32'h4, 32'd0, 4'd0);
        chk("pre_rst_valid", 64'(bus.rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(bus.req_ready), 64'd1);
        chk("post_rst_valid", 64'(bus.rsp_valid), 64'd0);
        bus.rsp_ready = 1'b1;
        lat_exact = 1'b1;
        read_check("persist_0x80", 32'h80, 32'hCAFEF00D);
        read_check("persist_0x10", 32'h10, 32'hDEADBEEF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
